uart_cmd_parser: RTL and testbench



---
 rtl/uart_cmd_parser.sv | 216 +++++++++++++++++++++
 tb/tb_uart_cmd_parser.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_parser.sv
// ============================================================================
// Module   : uart_cmd_parser
// Purpose  : Decodes ASCII-hex command lines ("Waadd<CR>" / "Raa<CR>") arriving
//            from the UART receiver into register write/read strobes.
// Options  : CMD_TIMEOUT_EN - drop a partial line after TIMEOUT_CYCLES idle clocks
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_cmd_parser #(
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int TIMEOUT_W      = 17
) (
  input  logic       CLK_10MHZ,
  input  logic       rst_n,
  input  logic       rx_ready,
  input  logic [7:0] rx_data,
  output logic       cmd_wr,
  output logic       cmd_rd,
  output logic [7:0] cmd_addr,
  output logic [7:0] cmd_wdata,
  output logic       frame_err,
  output logic [7:0] err_cnt
);

  localparam logic [7:0] C_CR = 8'h0D;
  localparam logic [7:0] C_LF = 8'h0A;
  localparam logic [7:0] C_SP = 8'h20;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ADDR_HI = 3'd1,
    S_ADDR_LO = 3'd2,
    S_DATA_HI = 3'd3,
    S_DATA_LO = 3'd4,
    S_EOL     = 3'd5,
    S_DISCARD = 3'd6
  } state_t;

  if ((TIMEOUT_CYCLES >> TIMEOUT_W) != 0) begin : g_bad_cfg
    $error("TIMEOUT_W too narrow for TIMEOUT_CYCLES");
  end

  state_t     state_q, state_d;
  logic       op_wr_q, op_wr_d;
  logic [7:0] addr_sh_q, addr_sh_d;
  logic [7:0] data_sh_q, data_sh_d;
  logic       cmd_wr_q, cmd_wr_d;
  logic       cmd_rd_q, cmd_rd_d;
  logic [7:0] cmd_addr_q, cmd_addr_d;
  logic [7:0] cmd_wdata_q, cmd_wdata_d;
  logic       frame_err_q, frame_err_d;
  logic [7:0] err_cnt_q, err_cnt_d;

  logic       w_is_hex;
  logic [3:0] w_nib;
  logic       w_is_w;
  logic       w_is_r;
  logic       w_err;
  logic       w_tmo_fire;

  always_comb begin
    w_is_hex = 1'b0;
    w_nib    = 4'h0;
    if (rx_data >= 8'h30 && rx_data <= 8'h39) begin
      w_is_hex = 1'b1;
      w_nib    = 4'(rx_data - 8'h30);
    end else if (rx_data >= 8'h41 && rx_data <= 8'h46) begin
      w_is_hex = 1'b1;
      w_nib    = 4'(rx_data - 8'h37);
    end else if (rx_data >= 8'h61 && rx_data <= 8'h66) begin
      w_is_hex = 1'b1;
      w_nib    = 4'(rx_data - 8'h57);
    end
  end

  assign w_is_w = (rx_data == 8'h57) || (rx_data == 8'h77);
  assign w_is_r = (rx_data == 8'h52) || (rx_data == 8'h72);

`ifdef CMD_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] tmo_q, tmo_d;

  always_comb begin
    tmo_d      = tmo_q;
    w_tmo_fire = 1'b0;
    if (rx_ready || state_q == S_IDLE) begin
      tmo_d = '0;
    end else if (tmo_q == TIMEOUT_W'(TIMEOUT_CYCLES - 1)) begin
      tmo_d      = '0;
      w_tmo_fire = 1'b1;
    end else begin
      tmo_d = tmo_q + 1'b1;
    end
  end

  always_ff @(posedge CLK_10MHZ or negedge rst_n) begin
    if (!rst_n) tmo_q <= '0;
    else        tmo_q <= tmo_d;
  end
`else
  assign w_tmo_fire = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    op_wr_d     = op_wr_q;
    addr_sh_d   = addr_sh_q;
    data_sh_d   = data_sh_q;
    cmd_wr_d    = 1'b0;
    cmd_rd_d    = 1'b0;
    cmd_addr_d  = cmd_addr_q;
    cmd_wdata_d = cmd_wdata_q;
    w_err       = 1'b0;

    // Spaces are transparent everywhere, so they never reach the state logic.
    if (rx_ready && rx_data != C_SP) begin
      unique case (state_q)
        S_IDLE: begin
          if (w_is_w) begin
            op_wr_d = 1'b1;
            state_d = S_ADDR_HI;
          end else if (w_is_r) begin
            op_wr_d = 1'b0;
            state_d = S_ADDR_HI;
          end else if (rx_data != C_CR && rx_data != C_LF) begin
            w_err = 1'b1;
          end
        end
        S_ADDR_HI: begin
          if (w_is_hex) begin
            addr_sh_d = {w_nib, addr_sh_q[3:0]};
            state_d   = S_ADDR_LO;
          end else w_err = 1'b1;
        end
        S_ADDR_LO: begin
          if (w_is_hex) begin
            addr_sh_d = {addr_sh_q[7:4], w_nib};
            state_d   = op_wr_q ? S_DATA_HI : S_EOL;
          end else w_err = 1'b1;
        end
        S_DATA_HI: begin
          if (w_is_hex) begin
            data_sh_d = {w_nib, data_sh_q[3:0]};
            state_d   = S_DATA_LO;
          end else w_err = 1'b1;
        end
        S_DATA_LO: begin
          if (w_is_hex) begin
            data_sh_d = {data_sh_q[7:4], w_nib};
            state_d   = S_EOL;
          end else w_err = 1'b1;
        end
        S_EOL: begin
          if (rx_data == C_CR) begin
            cmd_addr_d = addr_sh_q;
            if (op_wr_q) begin
              cmd_wdata_d = data_sh_q;
              cmd_wr_d    = 1'b1;
            end else begin
              cmd_rd_d = 1'b1;
            end
            state_d = S_IDLE;
          end else w_err = 1'b1;
        end
        S_DISCARD: begin
          if (rx_data == C_CR) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end

    // A CR that breaks a line also terminates it, so no discard is needed.
    if (w_err) state_d = (rx_data == C_CR) ? S_IDLE : S_DISCARD;
    if (w_tmo_fire) state_d = S_IDLE;

    frame_err_d = w_err | w_tmo_fire;
    err_cnt_d   = err_cnt_q;
    if (frame_err_d && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge CLK_10MHZ or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      op_wr_q     <= 1'b0;
      addr_sh_q   <= 8'h00;
      data_sh_q   <= 8'h00;
      cmd_wr_q    <= 1'b0;
      cmd_rd_q    <= 1'b0;
      cmd_addr_q  <= 8'h00;
      cmd_wdata_q <= 8'h00;
      frame_err_q <= 1'b0;
      err_cnt_q   <= 8'h00;
    end else begin
      state_q     <= state_d;
      op_wr_q     <= op_wr_d;
      addr_sh_q   <= addr_sh_d;
      data_sh_q   <= data_sh_d;
      cmd_wr_q    <= cmd_wr_d;
      cmd_rd_q    <= cmd_rd_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_wdata_q <= cmd_wdata_d;
      frame_err_q <= frame_err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign cmd_wr    = cmd_wr_q;
  assign cmd_rd    = cmd_rd_q;
  assign cmd_addr  = cmd_addr_q;
  assign cmd_wdata = cmd_wdata_q;
  assign frame_err = frame_err_q;
  assign err_cnt   = err_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_cmd_parser.sv
// ============================================================================
// Module   : tb_uart_cmd_parser
// Purpose  : Directed, table-driven bench for uart_cmd_parser.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_cmd_parser;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       cmd_wr;
  logic       cmd_rd;
  logic [7:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       frame_err;
  logic [7:0] err_cnt;

  int total = 0;
  int bad   = 0;

  int n_wr = 0, n_rd = 0, n_err = 0, n_both = 0;

  always #50 clk = ~clk;

  uart_cmd_parser #(
    .TIMEOUT_CYCLES(100),
    .TIMEOUT_W     (17)
  ) dut (
    .CLK_10MHZ(clk),
    .rst_n    (rst_n),
    .rx_ready (rx_ready),
    .rx_data  (rx_data),
    .cmd_wr   (cmd_wr),
    .cmd_rd   (cmd_rd),
    .cmd_addr (cmd_addr),
    .cmd_wdata(cmd_wdata),
    .frame_err(frame_err),
    .err_cnt  (err_cnt)
  );

  // Pulse counters; each strobe cycle counts once, so a stretched pulse shows up.
  always @(negedge clk) begin
    if (cmd_wr === 1'b1) n_wr <= n_wr + 1;
    if (cmd_rd === 1'b1) n_rd <= n_rd + 1;
    if (frame_err === 1'b1) n_err <= n_err + 1;
    if (cmd_wr === 1'b1 && cmd_rd === 1'b1) n_both <= n_both + 1;
  end

  typedef struct {
    string      txt;
    int         d_wr;
    int         d_rd;
    int         d_err;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] ecnt;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_ready = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int b_wr, b_rd, b_err;

    vecs[0]  = '{"W1A5C\r",        1, 0, 0, 8'h1A, 8'h5C, 8'h00};
    vecs[1]  = '{"r 0f\r\n",       0, 1, 0, 8'h0F, 8'h5C, 8'h00};
    vecs[2]  = '{"W1G23\r",        0, 0, 1, 8'h0F, 8'h5C, 8'h01};
    vecs[3]  = '{"W2233\r",        1, 0, 0, 8'h22, 8'h33, 8'h01};
    vecs[4]  = '{"w 4 4 b B \r",   1, 0, 0, 8'h44, 8'hBB, 8'h01};
    vecs[5]  = '{"W1\r",           0, 0, 1, 8'h44, 8'hBB, 8'h02};
    vecs[6]  = '{"R99\r",          0, 1, 0, 8'h99, 8'hBB, 8'h02};
    vecs[7]  = '{"W12345\r",       0, 0, 1, 8'h99, 8'hBB, 8'h03};
    vecs[8]  = '{"\n\nR7e\r",      0, 1, 0, 8'h7E, 8'hBB, 8'h03};
    vecs[9]  = '{"W0f9A\r",        1, 0, 0, 8'h0F, 8'h9A, 8'h03};
    vecs[10] = '{"R:0\r",          0, 0, 1, 8'h0F, 8'h9A, 8'h04};
    vecs[11] = '{"R@F\r",          0, 0, 1, 8'h0F, 8'h9A, 8'h05};
    vecs[12] = '{"Rg0\r",          0, 0, 1, 8'h0F, 8'h9A, 8'h06};
    vecs[13] = '{"Q\r",            0, 0, 1, 8'h0F, 8'h9A, 8'h07};
    vecs[14] = '{"W12\n34\r",      0, 0, 1, 8'h0F, 8'h9A, 8'h08};
    vecs[15] = '{"RAf\r",          0, 1, 0, 8'hAF, 8'h9A, 8'h08};

    rst_n    = 1'b0;
    rx_ready = 1'b0;
    rx_data  = 8'h00;
    idle(3);
    check("reset_outputs", {cmd_wr, cmd_rd, frame_err, cmd_addr, cmd_wdata, err_cnt},
          {3'b000, 8'h00, 8'h00, 8'h00});
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    for (int v = 0; v < 16; v++) begin
      b_wr = n_wr; b_rd = n_rd; b_err = n_err;
      send_str(vecs[v].txt);
      idle(3);
      check($sformatf("v%0d_wr", v),    n_wr - b_wr,   vecs[v].d_wr);
      check($sformatf("v%0d_rd", v),    n_rd - b_rd,   vecs[v].d_rd);
      check($sformatf("v%0d_err", v),   n_err - b_err, vecs[v].d_err);
      check($sformatf("v%0d_addr", v),  cmd_addr,      vecs[v].addr);
      check($sformatf("v%0d_wdata", v), cmd_wdata,     vecs[v].wdata);
      check($sformatf("v%0d_ecnt", v),  err_cnt,       vecs[v].ecnt);
    end

    // Back-to-back bytes, strobe expected exactly one cycle after CR.
    b_rd = n_rd;
    begin
      string s;
      s = "R12\r";
      for (int i = 0; i < s.len(); i++) begin
        @(negedge clk);
        rx_ready = 1'b1;
        rx_data  = s[i];
      end
    end
    @(negedge clk);
    rx_ready = 1'b0;
    #1;
    check("b2b_rd_pulse", {cmd_rd, cmd_wr}, 2'b10);
    check("b2b_addr", cmd_addr, 8'h12);
    @(negedge clk);
    #1;
    check("b2b_rd_low", cmd_rd, 1'b0);
    idle(2);
    check("b2b_rd_count", n_rd - b_rd, 1);

    // Error counter saturation.
    b_err = n_err;
    for (int k = 0; k < 256; k++) send_str("X\r");
    idle(3);
    check("sat_ecnt", err_cnt, 8'hFF);
    check("sat_pulses", n_err - b_err, 256);

    // Reset mid-line.
    send_str("W12");
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset_outputs", {cmd_wr, cmd_rd, frame_err, cmd_addr, cmd_wdata, err_cnt},
          {3'b000, 8'h00, 8'h00, 8'h00});
    @(negedge clk);
    rst_n = 1'b1;
    b_wr = n_wr; b_rd = n_rd;
    send_str("R34\r");
    idle(3);
    check("postreset_rd", n_rd - b_rd, 1);
    check("postreset_wr", n_wr - b_wr, 0);
    check("postreset_addr", cmd_addr, 8'h34);
    check("postreset_wdata", cmd_wdata, 8'h00);

    // Idle gap inside a line.
    b_wr = n_wr; b_rd = n_rd; b_err = n_err;
    send_str("W12");
`ifdef CMD_TIMEOUT_EN
    idle(95);
    check("tmo_not_early", n_err - b_err, 0);
    idle(10);
    check("tmo_err", n_err - b_err, 1);
    check("tmo_ecnt", err_cnt, 8'h01);
    send_str("R05\r");
    idle(3);
    check("tmo_rd", n_rd - b_rd, 1);
    check("tmo_wr", n_wr - b_wr, 0);
    check("tmo_addr", cmd_addr, 8'h05);
`else
    idle(110);
    check("gap_no_err", n_err - b_err, 0);
    check("gap_ecnt", err_cnt, 8'h00);
    send_str("34\r");
    idle(3);
    check("gap_wr", n_wr - b_wr, 1);
    check("gap_rd", n_rd - b_rd, 0);
    check("gap_addr", cmd_addr, 8'h12);
    check("gap_wdata", cmd_wdata, 8'h34);
`endif

    check("never_wr_and_rd", n_both, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
